// File: rtl/spu32_wishbone32_ram_pkg.sv
// ----------------------------------------------------------------------------
// spu32_wishbone32_ram_pkg
// Shared definitions for the Wishbone32 RAM responder:
//   - state_t    : service engine states (IDLE, EXEC)
//   - *_LSB      : bit offsets of the fields inside a queued request entry
//   - entry_width: total entry width for a given word-address width
//   - we_bit     : position of the write-enable flag (top bit of the entry)
// Entry layout, LSB first: sel[3:0] | dat[31:0] | adr[aw-1:0] | we
// ----------------------------------------------------------------------------
package spu32_wishbone32_ram_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_EXEC = 1'b1
   } state_t;

   localparam int SEL_LSB = 0;
   localparam int DAT_LSB = 4;
   localparam int ADR_LSB = 36;

   function automatic int entry_width(input int aw);
      return 1 + aw + 32 + 4;
   endfunction

   function automatic int we_bit(input int aw);
      return ADR_LSB + aw;
   endfunction

endpackage

// File: rtl/spu32_wishbone32_reqfifo.sv
// ----------------------------------------------------------------------------
// spu32_wishbone32_reqfifo
// Synchronous show-ahead FIFO holding pending bus requests.
// Ports:
//   I_clk, I_reset_n : clock, asynchronous active-low reset
//   I_flush          : empties the FIFO at the next edge (overrides push/pop)
//   I_push, I_data   : write request and entry; ignored while full
//   I_pop            : discard the head entry; ignored while empty
//   O_data           : current head entry (valid when !O_empty)
//   O_full, O_empty  : occupancy flags
//   O_count          : number of stored entries (0..DEPTH)
// ----------------------------------------------------------------------------
module spu32_wishbone32_reqfifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     I_clk,
   input  logic                     I_reset_n,
   input  logic                     I_flush,
   input  logic                     I_push,
   input  logic [WIDTH-1:0]         I_data,
   input  logic                     I_pop,
   output logic [WIDTH-1:0]         O_data,
   output logic                     O_full,
   output logic                     O_empty,
   output logic [$clog2(DEPTH):0]   O_count
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW:0]      wr_ptr_q, wr_ptr_d;
   logic [PW:0]      rd_ptr_q, rd_ptr_d;
   logic             push_ok, pop_ok;

   // The extra pointer MSB distinguishes full from empty when the indices match.
   assign O_count = wr_ptr_q - rd_ptr_q;
   assign O_full  = (O_count == (PW+1)'(DEPTH));
   assign O_empty = (wr_ptr_q == rd_ptr_q);
   assign O_data  = mem_q[rd_ptr_q[PW-1:0]];

   // A full FIFO refuses a push even if a pop frees a slot at the same edge.
   assign push_ok = I_push & ~O_full;
   assign pop_ok  = I_pop & ~O_empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q + {{PW{1'b0}}, push_ok};
      rd_ptr_d = rd_ptr_q + {{PW{1'b0}}, pop_ok};
      if (I_flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end
   end

   always_ff @(posedge I_clk or negedge I_reset_n) begin
      if (!I_reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage is not reset; only the pointers define validity.
   always_ff @(posedge I_clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q[PW-1:0]] <= I_data;
      end
   end

endmodule

// File: rtl/spu32_wishbone32_ram.sv
// ----------------------------------------------------------------------------
// spu32_wishbone32_ram
// Wishbone B4 pipelined responder in front of a single-ported 32-bit word RAM.
// Requests are queued in order, serviced one at a time with WAIT_STATES extra
// cycles each, and answered with single-cycle ACKs.
// Ports:
//   I_clk, I_reset_n : clock, asynchronous active-low reset
//   I_wb_cyc/stb/we  : bus cycle, strobe, write enable
//   I_wb_adr         : word address (only [ADDR_WIDTH-1:0] decoded)
//   I_wb_dat/sel     : write data and byte enables
//   O_wb_ack         : one-cycle acknowledge per accepted request
//   O_wb_stall       : request queue full, strobe not accepted
//   O_wb_dat         : read data, valid with a read ACK
// ----------------------------------------------------------------------------
module spu32_wishbone32_ram
   import spu32_wishbone32_ram_pkg::*;
#(
   parameter int ADDR_WIDTH  = 10,
   parameter int WAIT_STATES = 1,
   parameter int QUEUE_DEPTH = 4
) (
   input  logic        I_clk,
   input  logic        I_reset_n,
   input  logic        I_wb_cyc,
   input  logic        I_wb_stb,
   input  logic        I_wb_we,
   input  logic [29:0] I_wb_adr,
   input  logic [31:0] I_wb_dat,
   input  logic [3:0]  I_wb_sel,
   output logic        O_wb_ack,
   output logic        O_wb_stall,
   output logic [31:0] O_wb_dat
);

   localparam int         EW     = entry_width(ADDR_WIDTH);
   localparam int         WE_BIT = we_bit(ADDR_WIDTH);
   localparam int         CW     = $clog2(QUEUE_DEPTH) + 1;
   localparam logic [3:0] WS4    = 4'(WAIT_STATES);

   logic [31:0]           ram [2**ADDR_WIDTH];

   state_t                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [EW-1:0]         work_q, work_d;
   logic                  ack_q, ack_d;
   logic [31:0]           dat_q;

   logic                  push, pop, flush, access;
   logic                  q_full, q_empty;
   logic [CW-1:0]         q_count;
   logic [EW-1:0]         q_in, q_head;

   logic                  w_we;
   logic [ADDR_WIDTH-1:0] w_adr;
   logic [31:0]           w_dat;
   logic [3:0]            w_sel;
   logic                  unused_bits;

   assign unused_bits = ^{I_wb_adr[29:ADDR_WIDTH], q_full};

   assign q_in       = {I_wb_we, I_wb_adr[ADDR_WIDTH-1:0], I_wb_dat, I_wb_sel};
   assign O_wb_stall = (q_count == CW'(QUEUE_DEPTH));
   assign push       = I_wb_cyc & I_wb_stb & ~O_wb_stall;
   // Dropping CYC abandons every outstanding request.
   assign flush      = ~I_wb_cyc;

   spu32_wishbone32_reqfifo #(
      .WIDTH (EW),
      .DEPTH (QUEUE_DEPTH)
   ) u_reqfifo (
      .I_clk     (I_clk),
      .I_reset_n (I_reset_n),
      .I_flush   (flush),
      .I_push    (push),
      .I_data    (q_in),
      .I_pop     (pop),
      .O_data    (q_head),
      .O_full    (q_full),
      .O_empty   (q_empty),
      .O_count   (q_count)
   );

   assign w_we  = work_q[WE_BIT];
   assign w_adr = work_q[ADR_LSB +: ADDR_WIDTH];
   assign w_dat = work_q[DAT_LSB +: 32];
   assign w_sel = work_q[SEL_LSB +: 4];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      work_d  = work_q;
      ack_d   = 1'b0;
      pop     = 1'b0;
      access  = 1'b0;
      if (!I_wb_cyc) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (!q_empty) begin
                  pop     = 1'b1;
                  work_d  = q_head;
                  cnt_d   = WS4;
                  state_d = ST_EXEC;
               end
            end
            ST_EXEC: begin
               if (cnt_q != 4'd0) begin
                  cnt_d = cnt_q - 4'd1;
               end else begin
                  // Terminal edge: commit the access and chain straight into
                  // the next queued request so throughput is WAIT_STATES+1.
                  access = 1'b1;
                  ack_d  = 1'b1;
                  if (!q_empty) begin
                     pop    = 1'b1;
                     work_d = q_head;
                     cnt_d  = WS4;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge I_clk or negedge I_reset_n) begin
      if (!I_reset_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         work_q  <= '0;
         ack_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         work_q  <= work_d;
         ack_q   <= ack_d;
      end
   end

   // Read data register: only reads update it, so a write ACK keeps the
   // previously returned word on the bus.
   always_ff @(posedge I_clk or negedge I_reset_n) begin
      if (!I_reset_n) begin
         dat_q <= '0;
      end else if (access && !w_we) begin
         dat_q <= ram[w_adr];
      end
   end

   always_ff @(posedge I_clk) begin
      if (access && w_we) begin
         for (int b = 0; b < 4; b++) begin
            if (w_sel[b]) begin
               ram[w_adr][8*b +: 8] <= w_dat[8*b +: 8];
            end
         end
      end
   end

   assign O_wb_ack = ack_q;
   assign O_wb_dat = dat_q;

endmodule

// File: tb/tb_spu32_wishbone32_ram.sv
// ----------------------------------------------------------------------------
// tb_spu32_wishbone32_ram
// Three responder instances with WAIT_STATES = 1, 0, 3 (index 0, 1, 2),
// exercised with directed request lists and hand-computed expectations.
// ----------------------------------------------------------------------------
module tb_spu32_wishbone32_ram;

   logic        clk = 1'b0;
   logic        reset_n;

   logic        cyc_i   [3];
   logic        stb_i   [3];
   logic        we_i    [3];
   logic [29:0] adr_i   [3];
   logic [31:0] dat_i   [3];
   logic [3:0]  sel_i   [3];
   logic        ack_o   [3];
   logic        stall_o [3];
   logic [31:0] dat_o   [3];

   always #5 clk = ~clk;

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_dut
         localparam int WS = (gi == 0) ? 1 : ((gi == 1) ? 0 : 3);
         spu32_wishbone32_ram #(
            .ADDR_WIDTH  (10),
            .WAIT_STATES (WS),
            .QUEUE_DEPTH (4)
         ) u_dut (
            .I_clk      (clk),
            .I_reset_n  (reset_n),
            .I_wb_cyc   (cyc_i[gi]),
            .I_wb_stb   (stb_i[gi]),
            .I_wb_we    (we_i[gi]),
            .I_wb_adr   (adr_i[gi]),
            .I_wb_dat   (dat_i[gi]),
            .I_wb_sel   (sel_i[gi]),
            .O_wb_ack   (ack_o[gi]),
            .O_wb_stall (stall_o[gi]),
            .O_wb_dat   (dat_o[gi])
         );
      end
   endgenerate

   int n_cmp = 0;
   int n_bad = 0;

   logic        rq_we  [16];
   logic [29:0] rq_adr [16];
   logic [31:0] rq_dat [16];
   logic [3:0]  rq_sel [16];
   int          acc_cyc [16];
   int          ack_cyc [16];
   logic [31:0] ack_dat [16];
   int          n_ack;
   bit          stall_seen;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic set_rq(input int i, input logic we, input logic [29:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel);
      rq_we[i]  = we;
      rq_adr[i] = adr;
      rq_dat[i] = dat;
      rq_sel[i] = sel;
   endtask

   // Issue n queued requests on instance k, holding each strobe until it is
   // accepted, and log accept/ACK cycles. abort_edge != 0 drops CYC from that
   // edge on; the run then lasts the whole budget.
   task automatic run(input int k, input int n, input int abort_edge, input int budget);
      int  idx;
      int  cc;
      bit  acc;
      idx        = 0;
      cc         = 0;
      n_ack      = 0;
      stall_seen = 1'b0;
      cyc_i[k]   = 1'b1;
      while (cc < budget && !(abort_edge == 0 && n_ack == n)) begin
         if (abort_edge != 0 && cc + 1 >= abort_edge) begin
            cyc_i[k] = 1'b0;
            stb_i[k] = 1'b0;
         end else if (idx < n) begin
            stb_i[k] = 1'b1;
            we_i[k]  = rq_we[idx];
            adr_i[k] = rq_adr[idx];
            dat_i[k] = rq_dat[idx];
            sel_i[k] = rq_sel[idx];
         end else begin
            stb_i[k] = 1'b0;
         end
         if (stall_o[k]) stall_seen = 1'b1;
         acc = cyc_i[k] && stb_i[k] && !stall_o[k];
         @(posedge clk);
         cc++;
         if (acc) begin
            acc_cyc[idx] = cc;
            idx++;
         end
         #1;
         if (ack_o[k]) begin
            if (n_ack < 16) begin
               ack_cyc[n_ack] = cc;
               ack_dat[n_ack] = dat_o[k];
            end
            n_ack++;
         end
      end
      cyc_i[k] = 1'b0;
      stb_i[k] = 1'b0;
      @(posedge clk);
      #1;
      for (int i = 0; i < n_ack && i < 16; i++) begin
         $display("dut%0d tx%0d: %s adr=%03h acc@%0d ack@%0d dat_o=%08h", k, i,
                  rq_we[i] ? "WR" : "RD", rq_adr[i], acc_cyc[i], ack_cyc[i], ack_dat[i]);
      end
   endtask

   initial begin
      int cnt;
      reset_n = 1'b0;
      for (int k = 0; k < 3; k++) begin
         cyc_i[k] = 1'b0; stb_i[k] = 1'b0; we_i[k] = 1'b0;
         adr_i[k] = '0;   dat_i[k] = '0;   sel_i[k] = '0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         check_val($sformatf("rst_ack%0d", k),   32'(ack_o[k]),   32'd0);
         check_val($sformatf("rst_stall%0d", k), 32'(stall_o[k]), 32'd0);
         check_val($sformatf("rst_dat%0d", k),   dat_o[k],        32'd0);
      end
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // Single write then read, WAIT_STATES=1
      set_rq(0, 1'b1, 30'h005, 32'hDEADBEEF, 4'hF);
      run(0, 1, 0, 30);
      check_val("t1_wr_acks", 32'(n_ack), 32'd1);
      check_val("t1_wr_lat", 32'(ack_cyc[0] - acc_cyc[0]), 32'd3);
      check_val("t1_wr_dat_hold", ack_dat[0], 32'd0);
      set_rq(0, 1'b0, 30'h005, 32'h0, 4'hF);
      run(0, 1, 0, 30);
      check_val("t1_rd_acks", 32'(n_ack), 32'd1);
      check_val("t1_rd_lat", 32'(ack_cyc[0] - acc_cyc[0]), 32'd3);
      check_val("t1_rd_dat", ack_dat[0], 32'hDEADBEEF);

      // Byte masking
      set_rq(0, 1'b1, 30'h007, 32'h11223344, 4'hF);
      set_rq(1, 1'b1, 30'h007, 32'hAABBCCDD, 4'b0110);
      set_rq(2, 1'b0, 30'h007, 32'h0,        4'hF);
      run(0, 3, 0, 40);
      check_val("t2_acks", 32'(n_ack), 32'd3);
      check_val("t2_wr_hold", ack_dat[0], 32'hDEADBEEF);
      check_val("t2_rd_mask", ack_dat[2], 32'h11BBCC44);

      // Pipelined pair, WAIT_STATES=0
      set_rq(0, 1'b1, 30'h008, 32'hCAFEF00D, 4'hF);
      set_rq(1, 1'b1, 30'h009, 32'h01234567, 4'hF);
      run(1, 2, 0, 30);
      check_val("t3_wr_acks", 32'(n_ack), 32'd2);
      set_rq(0, 1'b0, 30'h008, 32'h0, 4'hF);
      set_rq(1, 1'b0, 30'h009, 32'h0, 4'hF);
      run(1, 2, 0, 30);
      check_val("t3_rd_acks", 32'(n_ack), 32'd2);
      check_val("t3_no_stall", 32'(stall_seen), 32'd0);
      check_val("t3_acc_b2b", 32'(acc_cyc[1] - acc_cyc[0]), 32'd1);
      check_val("t3_ack_b2b", 32'(ack_cyc[1] - ack_cyc[0]), 32'd1);
      check_val("t3_lat", 32'(ack_cyc[0] - acc_cyc[0]), 32'd2);
      check_val("t3_dat0", ack_dat[0], 32'hCAFEF00D);
      check_val("t3_dat1", ack_dat[1], 32'h01234567);

      // Queue full, WAIT_STATES=3
      for (int i = 0; i < 6; i++) set_rq(i, 1'b1, 30'(32'h10 + i), 32'h10000000 + 32'(i * 'h11), 4'hF);
      run(2, 6, 0, 100);
      check_val("t4_wr_acks", 32'(n_ack), 32'd6);
      for (int i = 0; i < 6; i++) set_rq(i, 1'b0, 30'(32'h10 + i), 32'h0, 4'hF);
      run(2, 6, 0, 100);
      check_val("t4_rd_acks", 32'(n_ack), 32'd6);
      check_val("t4_stall_seen", 32'(stall_seen), 32'd1);
      check_val("t4_lat", 32'(ack_cyc[0] - acc_cyc[0]), 32'd5);
      for (int i = 0; i < 6; i++) begin
         check_val($sformatf("t4_dat%0d", i), ack_dat[i], 32'h10000000 + 32'(i * 'h11));
         if (i > 0) check_val($sformatf("t4_gap%0d", i), 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd4);
      end

      // Abort: CYC drops at the terminal edge of the second write
      set_rq(0, 1'b1, 30'h020, 32'h00000000, 4'hF);
      set_rq(1, 1'b1, 30'h021, 32'h55555555, 4'hF);
      set_rq(2, 1'b1, 30'h022, 32'h55555555, 4'hF);
      run(0, 3, 0, 40);
      set_rq(0, 1'b1, 30'h020, 32'hA1A1A1A1, 4'hF);
      set_rq(1, 1'b1, 30'h021, 32'hA2A2A2A2, 4'hF);
      set_rq(2, 1'b1, 30'h022, 32'hA3A3A3A3, 4'hF);
      run(0, 3, 6, 20);
      check_val("t5_abort_acks", 32'(n_ack), 32'd1);
      set_rq(0, 1'b0, 30'h020, 32'h0, 4'hF);
      set_rq(1, 1'b0, 30'h021, 32'h0, 4'hF);
      set_rq(2, 1'b0, 30'h022, 32'h0, 4'hF);
      run(0, 3, 0, 40);
      check_val("t5_rd_acks", 32'(n_ack), 32'd3);
      check_val("t5_dat0", ack_dat[0], 32'hA1A1A1A1);
      check_val("t5_dat1", ack_dat[1], 32'h55555555);
      check_val("t5_dat2", ack_dat[2], 32'h55555555);

      // Address wrap
      set_rq(0, 1'b1, 30'h7FF, 32'h600DCAFE, 4'hF);
      set_rq(1, 1'b0, 30'h3FF, 32'h0,        4'hF);
      run(0, 2, 0, 30);
      check_val("t6_acks", 32'(n_ack), 32'd2);
      check_val("t6_wrap", ack_dat[1], 32'h600DCAFE);

      // Reset while EXEC is busy and the queue is full
      cyc_i[2] = 1'b1; stb_i[2] = 1'b1; we_i[2] = 1'b0;
      adr_i[2] = 30'h010; dat_i[2] = '0; sel_i[2] = 4'hF;
      repeat (5) @(posedge clk);
      #1;
      check_val("t7_stall_pre", 32'(stall_o[2]), 32'd1);
      #2;
      reset_n  = 1'b0;
      stb_i[2] = 1'b0;
      #1;
      check_val("t7_rst_ack", 32'(ack_o[2]), 32'd0);
      check_val("t7_rst_stall", 32'(stall_o[2]), 32'd0);
      check_val("t7_rst_dat", dat_o[2], 32'd0);
      #3;
      reset_n = 1'b1;
      cnt = 0;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk);
         #1;
         if (ack_o[2]) cnt++;
      end
      cyc_i[2] = 1'b0;
      $display("dut2 reset mid-EXEC: acks after release=%0d", cnt);
      check_val("t7_no_ack", 32'(cnt), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
